// File: rtl/alarme_pkg.sv
// rtl/alarme_pkg.sv - state encoding and timer width shared by the alarm controller
package alarme_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        DESARMADO = 3'd0,
        SAIDA     = 3'd1,
        ARMADO    = 3'd2,
        ENTRADA   = 3'd3,
        DISPARO   = 3'd4
    } estado_t;

endpackage

// File: rtl/alarme_temporizador.sv
// rtl/alarme_temporizador.sv - loadable down-counter with zero flag, holds at zero
module alarme_temporizador
    import alarme_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic [TIMER_W-1:0] valor,
    output logic               zero
);

    logic [TIMER_W-1:0] contagem;

    // load on state entry, otherwise count down and saturate at zero
    always_ff @(posedge clk) begin
        if (!resetn) begin
            contagem <= '0;
        end else if (load) begin
            contagem <= valor;
        end else if (contagem != '0) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign zero = (contagem == '0);

endmodule

// File: rtl/alarme_controlador.sv
// rtl/alarme_controlador.sv - intrusion alarm FSM (optional zone memory: ALARME_MEMORIA_EN)
module alarme_controlador
    import alarme_pkg::*;
#(
    parameter int T_SAIDA   = 16,
    parameter int T_ENTRADA = 16,
    parameter int T_SIRENE  = 64
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PORTA,
    input  logic       JANELA,
    input  logic       MOVIMENTO,
    input  logic       ARMAR,
    input  logic       DESARMAR,
    output logic       ALARME,
    output logic       ARMADO_LED,
`ifdef ALARME_MEMORIA_EN
    output logic [2:0] ZONA,
`endif
    output logic [2:0] ESTADO
);

    localparam logic [TIMER_W-1:0] CARGA_SAIDA   = TIMER_W'(T_SAIDA - 1);
    localparam logic [TIMER_W-1:0] CARGA_ENTRADA = TIMER_W'(T_ENTRADA - 1);
    localparam logic [TIMER_W-1:0] CARGA_SIRENE  = TIMER_W'(T_SIRENE - 1);

    estado_t            estado;
    estado_t            proximo;
    logic               carga;
    logic [TIMER_W-1:0] valor_carga;
    logic               tempo_zero;

    alarme_temporizador u_temporizador (
        .clk    (CLK),
        .resetn (RST_N),
        .load   (carga),
        .valor  (valor_carga),
        .zero   (tempo_zero)
    );

    // next-state decision; disarm overrides every other condition
    always_comb begin
        proximo = estado;
        if (DESARMAR) begin
            proximo = DESARMADO;
        end else begin
            case (estado)
                DESARMADO: if (ARMAR && !JANELA) proximo = SAIDA;
                SAIDA:     if (tempo_zero) proximo = ARMADO;
                ARMADO: begin
                    if (JANELA || MOVIMENTO) proximo = DISPARO;
                    else if (PORTA)          proximo = ENTRADA;
                end
                ENTRADA:   if (tempo_zero) proximo = DISPARO;
                DISPARO:   if (tempo_zero) proximo = ARMADO;
                default:   proximo = DESARMADO;
            endcase
        end
    end

    // the timer reloads on every state change with the new state's length minus one
    always_comb begin
        carga       = (proximo != estado);
        valor_carga = '0;
        case (proximo)
            SAIDA:   valor_carga = CARGA_SAIDA;
            ENTRADA: valor_carga = CARGA_ENTRADA;
            DISPARO: valor_carga = CARGA_SIRENE;
            default: valor_carga = '0;
        endcase
    end

    // state and all outputs registered from the same next-state value so they never skew
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            estado     <= DESARMADO;
            ALARME     <= 1'b0;
            ARMADO_LED <= 1'b0;
`ifdef ALARME_MEMORIA_EN
            ZONA       <= 3'b000;
`endif
        end else begin
            estado     <= proximo;
            ALARME     <= (proximo == DISPARO);
            ARMADO_LED <= (proximo != DESARMADO);
`ifdef ALARME_MEMORIA_EN
            if (proximo != estado) begin
                if (proximo == SAIDA)
                    ZONA <= 3'b000;
                else if (proximo == DISPARO || proximo == ENTRADA)
                    ZONA <= {PORTA, JANELA, MOVIMENTO};
            end
`endif
        end
    end

    assign ESTADO = estado;

endmodule

// File: doc/alarme_controlador.md
ALARME_CONTROLADOR -- requirements
Module: alarme_controlador

Interface
REQ-001 SHALL have parameter T_SAIDA, default 16: exit-delay length in CLK cycles (legal 2..255).
REQ-002 SHALL have parameter T_ENTRADA, default 16: entry-delay length in CLK cycles (legal 2..255).
REQ-003 SHALL have parameter T_SIRENE, default 64: siren-on length in CLK cycles (legal 2..255).
REQ-004 SHALL have port CLK  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port RST_N  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port PORTA  input  1: door sensor, 1 = open.
REQ-007 SHALL have port JANELA  input  1: window sensor, 1 = open.
REQ-008 SHALL have port MOVIMENTO  input  1: motion sensor, 1 = motion.
REQ-009 SHALL have port ARMAR  input  1: arm request, level sampled each cycle.
REQ-010 SHALL have port DESARMAR  input  1: disarm request, level sampled each cycle.
REQ-011 SHALL have port ALARME  output  1: siren drive, registered.
REQ-012 SHALL have port ARMADO_LED  output  1: 1 in any state except DESARMADO, registered.
REQ-013 SHALL have port ESTADO  output  3: current state encoding, registered.

Function
REQ-014 SHALL implement FSM states DESARMADO=0, SAIDA=1, ARMADO=2, ENTRADA=3, DISPARO=4; codes 5-7 unreachable, decoded as DESARMADO on next edge.
REQ-015 DESARMADO: ARMAR=1 and JANELA=0 -> SAIDA; ARMAR=1 with JANELA=1 ignored (stay).
REQ-016 SAIDA: all sensors ignored; exactly T_SAIDA cycles in state, then -> ARMADO.
REQ-017 ARMADO: JANELA=1 or MOVIMENTO=1 -> DISPARO next edge; else PORTA=1 -> ENTRADA next edge.
REQ-018 ENTRADA: sensors ignored; exactly T_ENTRADA cycles in state, then -> DISPARO.
REQ-019 DISPARO: ALARME=1 for exactly T_SIRENE cycles, then -> ARMADO; ALARME=0 in all other states.
REQ-020 DESARMAR=1 in any state -> DESARMADO next edge, ALARME=0 same edge; priority over ARMAR, timeouts and sensors.
REQ-021 Timer SHALL load (T-1) on state entry, decrement each cycle, transition when it reads 0; 8-bit, no wrap (holds 0).
REQ-022 Outputs ALARME, ARMADO_LED, ESTADO SHALL be registered, consistent with each other every cycle (no 1-cycle skew).

Reset
REQ-023 RST_N=0 at a rising edge SHALL force ESTADO=DESARMADO, ALARME=0, ARMADO_LED=0, timer=0, mid-delay or mid-siren included.
REQ-024 First edge with RST_N=1 SHALL evaluate REQ-015 normally (ARMAR held through reset release arms).

Configuration
REQ-025 With ALARME_MEMORIA_EN defined: add output ZONA (3 bits: {PORTA,JANELA,MOVIMENTO} sampled at entry to DISPARO or ENTRADA), held until next SAIDA entry or reset; reset value 0.
REQ-026 Without ALARME_MEMORIA_EN: no ZONA port, no memory register; all other behaviour identical.

Structure
REQ-027 Package alarme_pkg SHALL hold state encoding constants and timer width (8).
REQ-028 Sub-module alarme_temporizador SHALL implement the load/decrement/zero-flag timer; FSM stays in alarme_controlador.

Verification
REQ-029 Reset, ARMAR=1 one cycle, JANELA=0 -> ESTADO 0->1, ARMADO after exactly 16 cycles, ALARME=0 throughout.
REQ-030 In ARMADO, PORTA=1 one cycle -> ENTRADA; no DESARMAR -> DISPARO after 16 cycles, ALARME=1 for 64 cycles, back to ARMADO.
REQ-031 In ARMADO, MOVIMENTO=1 -> DISPARO next edge; DESARMAR=1 at siren cycle 10 -> ALARME=0, ESTADO=0 next edge.
REQ-032 DESARMADO, ARMAR=1 with JANELA=1 -> stays ESTADO=0; ARMAR=1 and DESARMAR=1 same cycle -> stays 0.
REQ-033 RST_N=0 during ENTRADA cycle 8 -> all outputs 0 next edge; with ALARME_MEMORIA_EN, ZONA=3'b100 after door trigger, 0 after reset.
